// File: rtl/if_prefetch_queue_pkg.sv
// Shared fetch-path definitions: default geometry, fetch FSM states and the
// {pc, instr} entry carried from the prefetch queue toward DOF.
package if_prefetch_queue_pkg;

  localparam int unsigned IFQ_DEPTH = 4;
  localparam int unsigned IFQ_AW    = 32;
  localparam int unsigned IFQ_DW    = 32;
  localparam logic [IFQ_AW-1:0] IFQ_RESET_PC = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [IFQ_AW-1:0] pc;
    logic [IFQ_DW-1:0] instr;
  } fetch_entry_t;

  // Word-addressed sequential successor, wrapping modulo 2^AW.
  function automatic logic [IFQ_AW-1:0] pc_next(input logic [IFQ_AW-1:0] pc);
    return pc + IFQ_AW'(1);
  endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO with synchronous clear; head entry is read
// combinationally from storage.
module if_prefetch_queue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  logic [W-1:0]           i_wdata,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_prefetch_queue.sv
// Decoupled instruction prefetch: sequential req/ack fetch engine feeding a
// small FIFO drained by DOF, with EX redirect flush and in-flight discard.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = IFQ_DEPTH,
  parameter int unsigned     AW       = IFQ_AW,
  parameter int unsigned     DW       = IFQ_DW,
  parameter logic [AW-1:0]   RESET_PC = AW'(IFQ_RESET_PC)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic          o_imem_req,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_ack,
  input  logic [DW-1:0] i_imem_rdata,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_pc,
  output logic          o_ir_valid,
  input  logic          i_ir_ready,
  output logic [DW-1:0] o_ir,
  output logic [AW-1:0] o_pc_m1
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = AW + DW;

  fetch_state_e  r_state;
  fetch_state_e  w_state_n;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] w_fetch_pc_n;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_n;
  logic          r_discard;
  logic          w_discard_n;

  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_space;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_after;
  logic [EW-1:0] w_head;

  if_prefetch_queue_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (i_redirect),
    .i_wdata ({r_addr, i_imem_rdata}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // A redirect kills both the returning word and any same-cycle pop.
  assign w_ack      = (r_state == ST_REQ) && i_imem_ack;
  assign w_push     = w_ack && !r_discard && !i_redirect;
  assign o_ir_valid = (w_count != '0);
  assign w_pop      = o_ir_valid && i_ir_ready && !i_redirect;

  // Occupancy after this edge; a new request is only issued if its word fits.
  always_comb begin
    w_count_after = w_count;
    if (i_redirect)
      w_count_after = '0;
    else if (w_push && !w_pop)
      w_count_after = w_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_after = w_count - CW'(1);
  end

  assign w_space = (w_count_after < CW'(DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_discard  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_fetch_pc <= w_fetch_pc_n;
      r_addr     <= w_addr_n;
      r_discard  <= w_discard_n;
    end
  end

  // r_fetch_pc is the next address to issue; r_addr is the address on the bus,
  // held untouched while a request waits so a redirect cannot disturb it.
  always_comb begin
    w_state_n    = r_state;
    w_fetch_pc_n = r_fetch_pc;
    w_addr_n     = r_addr;
    w_discard_n  = r_discard;

    case (r_state)
      ST_IDLE: begin
        if (!i_redirect && w_space) begin
          w_state_n    = ST_REQ;
          w_addr_n     = r_fetch_pc;
          w_fetch_pc_n = r_fetch_pc + AW'(1);
        end
      end
      ST_REQ: begin
        if (i_imem_ack) begin
          w_discard_n = 1'b0;
          if (!i_redirect && w_space) begin
            w_addr_n     = r_fetch_pc;
            w_fetch_pc_n = r_fetch_pc + AW'(1);
          end else begin
            w_state_n = ST_IDLE;
          end
        end else if (i_redirect) begin
          w_discard_n = 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    if (i_redirect) w_fetch_pc_n = i_redirect_pc;
  end

  assign o_imem_req  = (r_state == ST_REQ);
  assign o_imem_addr = r_addr;

  // Empty queue presents zeros, which stay stable until the next push.
  assign o_ir    = o_ir_valid ? w_head[DW-1:0] : '0;
  assign o_pc_m1 = o_ir_valid ? (w_head[EW-1:DW] + AW'(1)) : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized scoreboard bench for if_prefetch_queue: a memory responder with
// variable ACK latency, a program-order model of the FIFO and a negedge monitor.
module tb_if_prefetch_queue;
  import if_prefetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic [DW-1:0] ir;
  logic [AW-1:0] pc_m1;

  always #5 clk = ~clk;

  if_prefetch_queue #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .DW       (DW),
    .RESET_PC ('0)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_ir_valid    (ir_valid),
    .i_ir_ready    (ir_ready),
    .o_ir          (ir),
    .o_pc_m1       (pc_m1)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = {a[15:0], a[31:16]};
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678 ^ r;
  endfunction

  // Memory responder: per-request latency, data only meaningful with ACK.
  int            fixed_delay = 0;
  int unsigned   max_delay = 3;
  logic [AW-1:0] slow_addr = 32'hDEAD_0000;
  logic          resp_busy = 1'b0;
  int            wait_cnt = 0;

  function automatic int pick_delay(input logic [AW-1:0] a);
    if (a == slow_addr) return 2;
    if (fixed_delay >= 0) return fixed_delay;
    return int'($urandom_range(max_delay, 0));
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst_n || !imem_req) begin
      imem_ack  = 1'b0;
      resp_busy = 1'b0;
    end else begin
      if (!resp_busy) begin
        resp_busy = 1'b1;
        wait_cnt  = pick_delay(imem_addr);
      end
      if (wait_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        resp_busy  = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_cnt--;
      end
    end
  end

  // Reference model: FIFO contents in program order plus next expected fetch.
  fetch_entry_t  q[$];
  fetch_entry_t  e;
  logic [AW-1:0] exp_addr = '0;
  logic          stale = 1'b0;
  logic          held = 1'b0;
  logic [AW-1:0] held_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_addr = '0;
      stale    = 1'b0;
      held     = 1'b0;
      check("rst_req", 64'(imem_req), 64'(0));
      check("rst_valid", 64'(ir_valid), 64'(0));
      check("rst_addr", 64'(imem_addr), 64'(0));
      check("rst_pc_m1", 64'(pc_m1), 64'(0));
    end else begin
      check("ir_valid", 64'(ir_valid), 64'(q.size() != 0));
      if (ir_valid && q.size() != 0) begin
        check("ir", 64'(ir), 64'(q[0].instr));
        check("pc_m1", 64'(pc_m1), 64'(pc_next(q[0].pc)));
      end
      if (held) begin
        check("req_held", 64'(imem_req), 64'(1));
        check("addr_held", 64'(imem_addr), 64'(held_addr));
      end else if (imem_req) begin
        check("req_addr", 64'(imem_addr), 64'(exp_addr));
        check("req_space", 64'(q.size() < DEPTH), 64'(1));
      end
      if (ir_valid && ir_ready && !redirect && q.size() != 0) begin
        void'(q.pop_front());
        n_pops++;
      end
      if (imem_req && imem_ack) begin
        if (!stale && !redirect) begin
          e.pc    = imem_addr;
          e.instr = mem_word(imem_addr);
          q.push_back(e);
          check("no_overflow", 64'(q.size() <= DEPTH), 64'(1));
        end
        if (!stale) exp_addr = pc_next(imem_addr);
        stale = 1'b0;
      end
      if (redirect) begin
        q.delete();
        exp_addr = redirect_pc;
        if (imem_req && !imem_ack) stale = 1'b1;
      end
      held      = imem_req && !imem_ack;
      held_addr = imem_addr;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic wait_req_addr(input logic [AW-1:0] a, input int bound, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #2;
      if (imem_req && imem_addr == a) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 64'(found), 64'(1));
  endtask

  task automatic wait_valid(input int bound, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #2;
      if (ir_valid) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 64'(found), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);

    // Reset release with zero-wait memory and DOF always ready.
    fixed_delay = 0;
    ir_ready    = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #2;
    check("t1_req_rise", 64'(imem_req), 64'(1));
    check("t1_not_valid_yet", 64'(ir_valid), 64'(0));
    @(posedge clk); #2;
    check("t1_first_valid", 64'(ir_valid), 64'(1));
    check("t1_first_pc_m1", 64'(pc_m1), 64'(1));
    check("t1_first_ir", 64'(ir), 64'(mem_word('0)));
    repeat (20) @(posedge clk);

    // DOF stalled: queue fills to DEPTH and fetch stops, then drains in order.
    #1 ir_ready = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("t2_req_stopped", 64'(imem_req), 64'(0));
    check("t2_full_valid", 64'(ir_valid), 64'(1));
    ir_ready = 1'b1;
    repeat (20) @(posedge clk);

    // Slow memory: three wait cycles per fetch, random DOF stalls.
    fixed_delay = 3;
    repeat (40) begin
      @(posedge clk); #1 ir_ready = 1'($urandom % 2);
    end

    // Redirect to 0x40 while the fetch of address 5 is still waiting.
    fixed_delay = 0;
    ir_ready    = 1'b1;
    slow_addr   = 32'd5;
    do_reset();
    wait_req_addr(32'd5, 20, "t4_reach_addr5");
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(posedge clk); #1 redirect = 1'b0;
    #1;
    check("t4_flushed", 64'(ir_valid), 64'(0));
    check("t4_addr_still_5", 64'(imem_addr), 64'(5));
    wait_valid(12, "t4_refill");
    check("t4_pc_m1", 64'(pc_m1), 64'(32'h41));
    check("t4_ir", 64'(ir), 64'(mem_word(32'h40)));
    slow_addr = 32'hDEAD_0000;
    repeat (10) @(posedge clk);

    // Redirect coinciding with an ACK and a pop.
    @(posedge clk); #2;
    check("t5_ack_and_pop", 64'(imem_ack && ir_valid && ir_ready), 64'(1));
    redirect    = 1'b1;
    redirect_pc = 32'h1234_0000;
    @(posedge clk); #1 redirect = 1'b0;
    #1;
    check("t5_empty", 64'(ir_valid), 64'(0));
    wait_req_addr(32'h1234_0000, 6, "t5_fetch_target");
    repeat (10) @(posedge clk);

    // Address wrap at the top of memory, then async reset mid-cycle.
    @(posedge clk); #1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(posedge clk); #1 redirect = 1'b0;
    wait_req_addr(32'h0, 10, "t6_wrap_to_zero");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_req_drop", 64'(imem_req), 64'(0));
    check("t6_async_valid_drop", 64'(ir_valid), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #2;
    check("t6_restart_req", 64'(imem_req), 64'(1));
    check("t6_restart_addr", 64'(imem_addr), 64'(0));

    // Random soak: latency, stalls, redirects and occasional resets.
    fixed_delay = -1;
    max_delay   = 3;
    repeat (600) begin
      @(posedge clk); #1;
      ir_ready    = ($urandom % 4) != 0;
      redirect    = ($urandom % 20) == 0;
      redirect_pc = $urandom;
      if (($urandom % 250) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    rst_n    = 1'b1;
    ir_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("progress", 64'(n_pops > 150), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
